// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet MAC transmit/receive path.
package eth_pkg;

  // Transmit framer states, in on-wire order.
  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    HEADER,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } eth_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

  localparam int HDR_LEN = 14;
  localparam int FCS_LEN = 4;

  // One byte step of the reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 register; init has priority over en.
module eth_crc32 import eth_pkg::*; (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // Seed on init, fold in one byte per enabled cycle, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_crc <= '0;
    end else if (i_init) begin
      r_crc <= CRC32_INIT;
    end else if (i_en) begin
      r_crc <= crc32_byte(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/eth_tx.sv
// Ethernet MAC transmit framer: preamble, SFD, header, padded payload,
// FCS and inter-frame gap onto a byte-wide PHY interface.
module eth_tx import eth_pkg::*; #(
  parameter logic [47:0] SRC_MAC      = 48'h0011_2233_4455,
  parameter int          MIN_PAYLOAD  = 46,
  parameter int          MAX_PAYLOAD  = 1500,
  parameter int          PREAMBLE_LEN = 7,
  parameter int          IFG_BYTES    = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [47:0] i_dst_mac,
  input  logic [15:0] i_ethertype,
  input  logic [7:0]  i_s_byte,
  input  logic        i_s_valid,
  input  logic        i_s_last,
  output logic        o_s_ready,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_tx_err
);

  localparam logic [3:0]  L_PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0]  L_HDR_LAST = 4'(HDR_LEN - 1);
  localparam logic [3:0]  L_FCS_LAST = 4'(FCS_LEN - 1);
  localparam logic [3:0]  L_IFG_LAST = 4'(IFG_BYTES - 1);
  localparam logic [10:0] L_MIN      = 11'(MIN_PAYLOAD);
  localparam logic [10:0] L_MAX      = 11'(MAX_PAYLOAD);

  eth_state_e  r_state;
  logic [3:0]  r_idx;
  logic [10:0] r_pay_cnt;
  logic        r_discard;
  logic [47:0] r_dst_mac;
  logic [15:0] r_ethertype;
  logic        r_tx_err;

  logic             w_xfer;
  logic             w_s_acc;
  logic [10:0]      w_cnt_next;
  logic [13:0][7:0] w_hdr_bytes;
  logic [3:0][7:0]  w_fcs_bytes;
  logic [31:0]      w_crc;
  logic             w_crc_init;
  logic             w_crc_en;

  assign w_xfer      = o_tx_valid && i_tx_ready;
  assign w_s_acc     = i_s_valid && o_s_ready;
  assign w_cnt_next  = r_pay_cnt + 11'd1;
  assign w_hdr_bytes = {r_dst_mac, SRC_MAC, r_ethertype};
  assign w_fcs_bytes = ~w_crc;

  // CRC restarts at SFD and covers every header, payload and pad transfer.
  assign w_crc_init = (r_state == SFD);
  assign w_crc_en   = w_xfer && ((r_state == HEADER) || (r_state == PAYLOAD) ||
                                 (r_state == PAD));

  eth_crc32 u_crc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_init  (w_crc_init),
    .i_en    (w_crc_en),
    .i_data  (o_tx_byte),
    .o_crc   (w_crc)
  );

  // Output decode from registered state; payload passes straight through.
  always_comb begin
    o_tx_byte  = 8'h00;
    o_tx_valid = 1'b0;
    o_s_ready  = 1'b0;
    case (r_state)
      PREAMBLE: begin
        o_tx_byte  = PREAMBLE_BYTE;
        o_tx_valid = 1'b1;
      end
      SFD: begin
        o_tx_byte  = SFD_BYTE;
        o_tx_valid = 1'b1;
      end
      HEADER: begin
        o_tx_byte  = w_hdr_bytes[L_HDR_LAST - r_idx];
        o_tx_valid = 1'b1;
      end
      PAYLOAD: begin
        o_tx_byte  = i_s_byte;
        o_tx_valid = i_s_valid;
        o_s_ready  = i_tx_ready;
      end
      PAD: begin
        o_tx_valid = 1'b1;
      end
      FCS: begin
        o_tx_byte  = w_fcs_bytes[r_idx[1:0]];
        o_tx_valid = 1'b1;
      end
      IFG, IDLE: begin
        o_s_ready  = r_discard;
      end
      default: begin
        o_s_ready  = 1'b0;
      end
    endcase
  end

  // Frame sequencing, byte counters, truncation and discard tracking.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_pay_cnt   <= '0;
      r_discard   <= 1'b0;
      r_dst_mac   <= '0;
      r_ethertype <= '0;
      r_tx_err    <= 1'b0;
    end else begin
      r_tx_err <= 1'b0;
      if (r_discard && w_s_acc && i_s_last) begin
        r_discard <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (i_s_valid && !r_discard) begin
            r_dst_mac   <= i_dst_mac;
            r_ethertype <= i_ethertype;
            r_idx       <= '0;
            r_state     <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (w_xfer) begin
            if (r_idx == L_PRE_LAST) begin
              r_idx   <= '0;
              r_state <= SFD;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        SFD: begin
          if (w_xfer) begin
            r_idx   <= '0;
            r_state <= HEADER;
          end
        end
        HEADER: begin
          if (w_xfer) begin
            if (r_idx == L_HDR_LAST) begin
              r_idx     <= '0;
              r_pay_cnt <= '0;
              r_state   <= PAYLOAD;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        PAYLOAD: begin
          if (w_xfer) begin
            r_pay_cnt <= w_cnt_next;
            if (i_s_last) begin
              r_idx   <= '0;
              r_state <= (w_cnt_next < L_MIN) ? PAD : FCS;
            end else if (w_cnt_next == L_MAX) begin
              r_tx_err  <= 1'b1;
              r_discard <= 1'b1;
              r_idx     <= '0;
              r_state   <= FCS;
            end
          end
        end
        PAD: begin
          if (w_xfer) begin
            r_pay_cnt <= w_cnt_next;
            if (w_cnt_next == L_MIN) begin
              r_idx   <= '0;
              r_state <= FCS;
            end
          end
        end
        FCS: begin
          if (w_xfer) begin
            if (r_idx == L_FCS_LAST) begin
              r_idx   <= '0;
              r_state <= IFG;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        IFG: begin
          if (i_tx_ready) begin
            if (r_idx == L_IFG_LAST) begin
              r_idx   <= '0;
              r_state <= IDLE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy   = (r_state != IDLE);
  assign o_tx_err = r_tx_err;

endmodule
